// File: rtl/dmem_responder.sv
// Data-memory responder for the multicycle RV32I core.
// Takes one load/store request at a time through a valid/ready handshake.
// The access happens after a programmable number of wait cycles, and the result is held
// in registers until the requester takes it. Bad accesses are reported through rsp_err
// and never change memory.
module dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [32:0] BYTE_LIMIT = 33'(4 * DEPTH);
  localparam logic [3:0]  LAST_CNT   = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic          inIdle;
  logic          accept;
  logic          enterResp;
  logic          effWe;
  logic [2:0]    effFunct3;
  logic [31:0]   effAddr;
  logic [31:0]   effWdata;
  logic [AW-1:0] effIdx;
  logic [31:0]   memWord;
  logic [7:0]    laneByte;
  logic [15:0]   laneHalf;
  logic          accessErr;
  logic [31:0]   loadData;
  logic [31:0]   newWord;

  assign inIdle = (state_q == S_IDLE);
  assign accept = req_valid & inIdle;

  // With zero wait cycles, RESP is entered on the accept edge itself.
  // The live request must therefore be used there, because nothing has been latched yet.
  assign effWe     = inIdle ? req_we     : we_q;
  assign effFunct3 = inIdle ? req_funct3 : funct3_q;
  assign effAddr   = inIdle ? req_addr   : addr_q;
  assign effWdata  = inIdle ? req_wdata  : wdata_q;
  assign effIdx    = effAddr[AW+1:2];
  assign memWord   = mem[effIdx];
  assign laneByte  = memWord[{effAddr[1:0], 3'b000} +: 8];
  assign laneHalf  = effAddr[1] ? memWord[31:16] : memWord[15:0];

  assign enterResp = (accept && (WAIT_CYCLES == 0)) ||
                     ((state_q == S_WAIT) && (cnt_q == LAST_CNT));

  // Classify the access.
  // A rejected request is misaligned, outside the array, uses an unknown width code,
  // or is an unsigned store.
  always_comb begin
    accessErr = 1'b0;
    case (effFunct3)
      3'b000, 3'b100: accessErr = effWe && effFunct3[2];
      3'b001, 3'b101: accessErr = effAddr[0] || (effWe && effFunct3[2]);
      3'b010:         accessErr = (effAddr[1:0] != 2'b00);
      default:        accessErr = 1'b1;
    endcase
    if ({1'b0, effAddr} >= BYTE_LIMIT) begin
      accessErr = 1'b1;
    end
  end

  // Select the addressed lane and extend it.
  // The store path merges the new bytes into the existing word.
  always_comb begin
    loadData = 32'd0;
    newWord  = memWord;
    case (effFunct3)
      3'b000: loadData = {{24{laneByte[7]}}, laneByte};
      3'b001: loadData = {{16{laneHalf[15]}}, laneHalf};
      3'b010: loadData = memWord;
      3'b100: loadData = {24'd0, laneByte};
      3'b101: loadData = {16'd0, laneHalf};
      default: loadData = 32'd0;
    endcase
    case (effFunct3)
      3'b000:  newWord[{effAddr[1:0], 3'b000} +: 8] = effWdata[7:0];
      3'b001:  newWord[{effAddr[1], 4'b0000} +: 16] = effWdata[15:0];
      3'b010:  newWord = effWdata;
      default: newWord = memWord;
    endcase
  end

  // Next-state logic for the handshake FSM.
  // It also loads the response registers when the access resolves.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
          cnt_d   = 4'd0;
        end
      end
      S_WAIT: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (enterResp) begin
      err_d   = accessErr;
      rdata_d = (accessErr || effWe) ? 32'd0 : loadData;
    end
  end

  // State, counter, response registers and the latched copy of the accepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
    end
  end

  // Memory array with no reset.
  // A store commits on the edge that enters RESP, unless reset drops it first.
  always_ff @(posedge clk) begin
    if (!rst && enterResp && effWe && !accessErr) begin
      mem[effIdx] <= newWord;
    end
  end

  assign req_ready = inIdle;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
